wr_feeder: RTL and testbench

WR_FEEDER -- requirements
Module: wr_feeder

---
 rtl/wr_feeder.sv | 125 ++++++++++++
 tb/tb_wr_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_feeder.sv
// Write-side feeder: buffers producer words and hands them one at a
// time to the FIFO write controller through a req/ack handshake.
module wr_feeder #(
  parameter int DATA_W      = 8,
  parameter int BUF_DEPTH   = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                         wr_clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         wr_req_,
  output logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_en,
  input  logic                         full,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic [7:0]                   retry_cnt,
  output logic                         proto_err
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    BACKOFF
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     wait_cnt;
  logic              push;
  logic              pop;
  logic              timeout;
  logic              has_work;
  logic              req_nx;
  logic              req_q;

  assign in_ready  = count < CW'(BUF_DEPTH);
  assign push      = in_valid && in_ready;
  assign pop       = wr_en && (state == WAIT);
  assign timeout   = (state == WAIT) && !wr_en &&
                     (wait_cnt == TW'(ACK_TIMEOUT));
  assign has_work  = (count != '0) && !full;
  assign buf_count = count;
  assign wr_req_   = req_q;
  assign wr_data   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge wr_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (has_work) state_nx = REQ;
      REQ:     state_nx = WAIT;
      WAIT: begin
        if (wr_en)        state_nx = IDLE;
        else if (timeout) state_nx = BACKOFF;
      end
      BACKOFF: if (has_work) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Request is registered so it is low exactly while in REQ.
  always_comb begin
    req_nx = 1'b1;
    if (state_nx == REQ) req_nx = 1'b0;
  end

  always_ff @(posedge wr_clk) begin
    if (rst) req_q <= 1'b1;
    else     req_q <= req_nx;
  end

  always_ff @(posedge wr_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst)                wait_cnt <= '0;
    else if (state == REQ)  wait_cnt <= TW'(1);
    else if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      retry_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      if (timeout && retry_cnt != 8'hFF)
        retry_cnt <= retry_cnt + 8'd1;
      if (wr_en && state != WAIT)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_feeder.sv
// Bench for wr_feeder: ack model of the write controller plus
// a scoreboard that checks every acknowledged word in order.
module tb_wr_feeder;

  logic       wr_clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_req_;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [2:0] buf_count;
  logic [7:0] retry_cnt;
  logic       proto_err;

  int         checks = 0;
  int         failures = 0;
  int         req_lows = 0;
  logic [7:0] q[$];
  bit         ack_en = 1'b1;
  bit         stray = 1'b0;
  bit         ack_wr_en = 1'b0;
  logic [7:0] sh = '0;
  int         ack_lat = 3;

  assign wr_en = ack_wr_en | stray;

  wr_feeder #(
    .DATA_W(8),
    .BUF_DEPTH(4),
    .ACK_TIMEOUT(4)
  ) dut (
    .wr_clk(wr_clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wr_req_(wr_req_),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .buf_count(buf_count),
    .retry_cnt(retry_cnt),
    .proto_err(proto_err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // Write-controller model: ack ack_lat cycles after a low request.
  initial begin
    forever begin
      @(negedge wr_clk);
      sh = {sh[6:0], ack_en && (wr_req_ === 1'b0)};
      if (wr_req_ === 1'b0) req_lows++;
      @(posedge wr_clk);
      #1;
      ack_wr_en = sh[ack_lat-1];
    end
  end

  // Scoreboard monitor: every ack must see the oldest pushed word.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge wr_clk);
      if (ack_wr_en && !rst) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL ack_nodata wr_data=%0h expected none", wr_data);
        end else begin
          exp = q.pop_front();
          if (wr_data !== exp) begin
            failures++;
            $display("FAIL ack_data got=%0h expected=%0h", wr_data, exp);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge wr_clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    q.push_back(d);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((buf_count != 3'd0 || q.size() != 0) && n < budget) begin
      tick;
      n++;
    end
    chk({nm, "_cnt"}, 32'(buf_count), 0);
    chk({nm, "_q"}, q.size(), 0);
  endtask

  initial begin
    int n0;
    int n;
    int k;
    logic [7:0] word;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    full     = 1'b0;
    repeat (3) tick;
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_req", 32'(wr_req_), 1);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_cnt", 32'(buf_count), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_perr", 32'(proto_err), 0);
    rst = 1'b0;
    tick;

    // single word
    n0 = req_lows;
    push_one(8'hA5);
    chk("single_cnt1", 32'(buf_count), 1);
    chk("single_head", 32'(wr_data), 32'hA5);
    drain("single", 40);
    chk("single_reqs", req_lows - n0, 1);
    chk("single_retry", 32'(retry_cnt), 0);
    chk("single_empty_data", 32'(wr_data), 0);

    // fill with the controller full, then release
    full = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      q.push_back(8'(i));
      tick;
    end
    in_data = 8'h05;
    chk("fill_ready", 32'(in_ready), 0);
    chk("fill_cnt", 32'(buf_count), 4);
    tick;
    in_valid = 1'b0;
    chk("fill_no5th", 32'(buf_count), 4);
    n0 = req_lows;
    repeat (5) tick;
    chk("stall_req", 32'(wr_req_), 1);
    chk("stall_reqs", req_lows - n0, 0);
    full = 1'b0;
    tick;
    chk("stall_release", 32'(wr_req_), 0);
    drain("fill", 60);
    chk("fill_reqs", req_lows - n0, 4);
    chk("fill_retry", 32'(retry_cnt), 0);

    // ack on the timeout cycle wins
    ack_lat = 4;
    push_one(8'h3C);
    drain("tmo_edge", 40);
    chk("tmo_edge_retry", 32'(retry_cnt), 0);
    chk("tmo_edge_perr", 32'(proto_err), 0);
    ack_lat = 3;

    // timeout then successful retry
    ack_en = 1'b0;
    push_one(8'h5A);
    n = 0;
    while (retry_cnt != 8'd1 && n < 30) begin
      tick;
      n++;
    end
    chk("tmo_retry1", 32'(retry_cnt), 1);
    chk("tmo_backoff_req", 32'(wr_req_), 1);
    ack_en = 1'b1;
    drain("tmo", 40);
    chk("tmo_keep", 32'(retry_cnt), 1);

    // saturation
    ack_en = 1'b0;
    push_one(8'h77);
    repeat (300 * 6 + 10) tick;
    chk("sat", 32'(retry_cnt), 255);
    ack_en = 1'b1;
    drain("sat", 40);
    chk("sat_hold", 32'(retry_cnt), 255);

    // push and pop in the same cycle at two entries
    full = 1'b1;
    push_one(8'h10);
    push_one(8'h11);
    full = 1'b0;
    word = 8'h12;
    k = 0;
    for (int c = 0; c < 100 && k < 6; c++) begin
      if (ack_wr_en) begin
        in_valid = 1'b1;
        in_data  = word;
        q.push_back(word);
        chk("sim_pre", 32'(buf_count), 2);
        tick;
        in_valid = 1'b0;
        chk("sim_post", 32'(buf_count), 2);
        word++;
        k++;
      end else begin
        tick;
      end
    end
    chk("sim_pairs", k, 6);
    drain("sim", 40);

    // stray ack while idle
    full = 1'b1;
    push_one(8'h99);
    stray = 1'b1;
    tick;
    stray = 1'b0;
    chk("stray_perr", 32'(proto_err), 1);
    chk("stray_cnt", 32'(buf_count), 1);

    // reset in the middle of a wait
    full = 1'b0;
    ack_en = 1'b0;
    n = 0;
    while (wr_req_ !== 1'b0 && n < 10) begin
      tick;
      n++;
    end
    chk("midwait_req", 32'(wr_req_), 0);
    tick;
    rst = 1'b1;
    stray = 1'b1;
    tick;
    chk("midrst_req", 32'(wr_req_), 1);
    chk("midrst_cnt", 32'(buf_count), 0);
    stray = 1'b0;
    tick;
    chk("midrst_perr", 32'(proto_err), 0);
    chk("midrst_retry", 32'(retry_cnt), 0);
    chk("midrst_data", 32'(wr_data), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    q.delete();
    rst = 1'b0;
    ack_en = 1'b1;
    n0 = req_lows;
    repeat (10) tick;
    chk("post_cnt", 32'(buf_count), 0);
    chk("post_reqs", req_lows - n0, 0);
    chk("post_perr", 32'(proto_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
